dmem_arbiter: RTL and testbench

//  Round-robin arbiter that shares one data memory port between num_cores_p cores.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_pick.sv | 33 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: core/memory handshake structs and FSM states.
// No logic; no latency and no backpressure of its own.
package dmem_arbiter_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic        yumi;
    logic [31:0] read_data;
  } mem_out_s;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after i_ptr, wrapping modulo num_cores_p.
// Purely combinational, zero latency; it never stalls a requester itself.
module dmem_arbiter_rr_pick #(
  parameter int num_cores_p = 4,
  localparam int IdxW = $clog2(num_cores_p)
) (
  input  logic [num_cores_p-1:0] i_req,
  input  logic [IdxW-1:0]        i_ptr,
  output logic [num_cores_p-1:0] o_grant,
  output logic [IdxW-1:0]        o_idx,
  output logic                   o_any
);

  logic [IdxW:0] w_idx;

  // Walk from the farthest candidate back to i_ptr so the closest requester is written last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = num_cores_p - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_ptr} + (IdxW+1)'(k);
      if (w_idx >= (IdxW+1)'(num_cores_p)) w_idx = w_idx - (IdxW+1)'(num_cores_p);
      if (i_req[w_idx[IdxW-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_idx[IdxW-1:0];
      end
    end
    o_grant[o_idx] = o_any;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of one data-memory port among num_cores_p cores, one transaction at a time.
// Arbitration costs one idle cycle; the grant is held until the owner consumes the response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int num_cores_p = 4,
  parameter int timeout_p   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  mem_in_s  [num_cores_p-1:0]   core_req_i,
  input  logic [num_cores_p-1:0][31:0] core_addr_i,
  output mem_out_s [num_cores_p-1:0]   core_resp_o,
  output mem_in_s                      mem_req_o,
  output logic [31:0]                  mem_addr_o,
  input  mem_out_s                     mem_resp_i,
  output logic [num_cores_p-1:0]       grant_o,
  output logic                         err_o
);

  localparam int IdxW = $clog2(num_cores_p);
  localparam int TmoW = $clog2(timeout_p + 1);

  arb_state_e             r_state, w_state_nxt;
  logic [num_cores_p-1:0] r_grant, w_grant_nxt;
  logic [IdxW-1:0]        r_owner, w_owner_nxt;
  logic [IdxW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [TmoW-1:0]        r_tmo_cnt, w_tmo_cnt_nxt;
  logic                   r_err, w_err_nxt;

  logic [num_cores_p-1:0] w_req_vld;
  logic [num_cores_p-1:0] w_pick_grant;
  logic [IdxW-1:0]        w_pick_idx;
  logic                   w_pick_any;
  logic [IdxW-1:0]        w_owner_inc;
  logic                   w_tmo_hit;
  mem_in_s                w_own_req;

  always_comb begin
    w_req_vld = '0;
    for (int i = 0; i < num_cores_p; i++) w_req_vld[i] = core_req_i[i].valid;
  end

  dmem_arbiter_rr_pick #(.num_cores_p(num_cores_p)) u_pick (
    .i_req   (w_req_vld),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_own_req   = core_req_i[r_owner];
  assign w_owner_inc = (r_owner == IdxW'(num_cores_p - 1)) ? '0 : r_owner + 1'b1;
  // Abort on the edge where the count reaches timeout_p; no yumi leaves in that cycle.
  assign w_tmo_hit   = (r_state != S_IDLE) && (r_tmo_cnt == TmoW'(timeout_p - 1));
  assign grant_o     = r_grant;
  assign err_o       = r_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_err_nxt     = r_err;
    mem_req_o     = '0;
    mem_addr_o    = '0;
    core_resp_o   = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt   = S_REQ;
          w_grant_nxt   = w_pick_grant;
          w_owner_nxt   = w_pick_idx;
          w_tmo_cnt_nxt = '0;
        end
      end
      S_REQ: begin
        mem_req_o                 = w_own_req;
        mem_req_o.yumi            = 1'b0;
        mem_addr_o                = core_addr_i[r_owner];
        core_resp_o[r_owner].yumi = mem_resp_i.yumi & ~w_tmo_hit;
        w_tmo_cnt_nxt             = r_tmo_cnt + 1'b1;
        if (w_tmo_hit || !w_own_req.valid) begin
          w_state_nxt  = S_IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = w_owner_inc;
          w_err_nxt    = r_err | w_tmo_hit;
        end else if (mem_resp_i.yumi) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        mem_req_o.yumi                 = w_own_req.yumi & ~w_tmo_hit;
        core_resp_o[r_owner].valid     = mem_resp_i.valid & ~w_tmo_hit;
        core_resp_o[r_owner].read_data = mem_resp_i.read_data;
        w_tmo_cnt_nxt                  = r_tmo_cnt + 1'b1;
        if (w_tmo_hit || (mem_resp_i.valid && w_own_req.yumi)) begin
          w_state_nxt  = S_IDLE;
          w_grant_nxt  = '0;
          w_rr_ptr_nxt = w_owner_inc;
          w_err_nxt    = r_err | w_tmo_hit;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random cores and memory against a transaction-level arbitration model,
// plus directed timeout, abandon and mid-transaction reset scenarios.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int TXN = 30;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  mem_in_s  [N-1:0]   core_req;
  logic [N-1:0][31:0] core_addr;
  mem_out_s [N-1:0]   core_resp;
  mem_in_s            mem_req;
  logic [31:0]        mem_addr;
  mem_out_s           mem_resp;
  logic [N-1:0]       grant;
  logic               err;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.num_cores_p(N), .timeout_p(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req_i  (core_req),
    .core_addr_i (core_addr),
    .core_resp_o (core_resp),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_resp_i  (mem_resp),
    .grant_o     (grant),
    .err_o       (err)
  );

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic clear_inputs();
    core_req  = '0;
    core_addr = '0;
    mem_resp  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (mem_req.valid !== 1'b0 || mem_req.yumi !== 1'b0)
      begin errors++; $display("FAIL reset_mem_req: got v=%b y=%b want 0 0", mem_req.valid, mem_req.yumi); end
    checks++; if (core_resp !== '0) begin errors++; $display("FAIL reset_core_resp: got %h want 0", core_resp); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int          c_st [N];
    int          c_left [N];
    int          c_wq [N];
    int          c_starve [N];
    logic        c_yumi [N];
    logic [31:0] c_adr [N];
    logic [31:0] c_wd [N];
    logic        c_wen [N];
    logic        c_bnw [N];
    int          m_ph, m_cnt, m_ydly, owner, ptr, total, w, o;
    logic        m_seen, m_yumi, m_vld, busy, mem_ack, exp_cy, exp_cv, exp_mv, exp_my;
    logic [31:0] m_adr, m_last_addr;
    logic [N-1:0] vld_now;
    do_reset();
    for (int i = 0; i < N; i++) begin
      c_st[i] = 0; c_left[i] = TXN; c_wq[i] = 0; c_starve[i] = 0; c_yumi[i] = 1'b0;
      c_adr[i] = '0; c_wd[i] = '0; c_wen[i] = 1'b0; c_bnw[i] = 1'b0;
    end
    m_ph = 0; m_cnt = 0; m_ydly = 0; owner = 0; ptr = 0; total = 0;
    m_seen = 1'b0; busy = 1'b0; m_adr = '0; m_last_addr = '0;
    for (int cyc = 0; cyc < 6000 && total < N * TXN; cyc++) begin
      @(negedge clk);
      // Cores: 0 idle, 1 requesting (valid held until yumi), 2 waiting for response
      for (int i = 0; i < N; i++) begin
        if (c_st[i] == 0 && c_left[i] > 0 && $urandom_range(3) == 0) begin
          c_st[i] = 1; c_adr[i] = $urandom & 32'hFFFF_FFFC; c_wd[i] = $urandom;
          c_wen[i] = 1'($urandom_range(1)); c_bnw[i] = 1'($urandom_range(1));
        end
        c_yumi[i] = (c_st[i] == 2) && ($urandom_range(1) == 1 || c_wq[i] >= 1);
        if (c_st[i] == 2) c_wq[i]++;
        vld_now[i]                  = (c_st[i] == 1);
        core_req[i].valid           = vld_now[i];
        core_req[i].write_data      = vld_now[i] ? c_wd[i] : 32'h0;
        core_req[i].wen             = vld_now[i] & c_wen[i];
        core_req[i].byte_not_word   = vld_now[i] & c_bnw[i];
        core_req[i].yumi            = c_yumi[i];
        core_addr[i]                = vld_now[i] ? c_adr[i] : 32'h0;
      end
      m_yumi = 1'b0;
      m_vld  = 1'b0;
      if (m_ph == 0) begin
        if (m_seen) begin
          if (m_ydly == 0) begin
            m_yumi = 1'b1; m_adr = m_last_addr; m_cnt = $urandom_range(2); m_ph = 1; m_vld = (m_cnt == 0);
          end else m_ydly--;
        end
      end else begin
        if (m_cnt > 0) m_cnt--;
        m_vld = (m_cnt == 0);
      end
      mem_resp.yumi      = m_yumi;
      mem_resp.valid     = m_vld;
      mem_resp.read_data = m_vld ? rd_of(m_adr) : $urandom;
      #1;
      mem_ack = 1'b0;
      if (!busy) begin
        checks++; if (grant !== '0) begin errors++; $display("FAIL rnd_idle_grant: got %b want 0", grant); end
        checks++; if (mem_req.valid !== 1'b0 || mem_req.yumi !== 1'b0)
          begin errors++; $display("FAIL rnd_idle_mem: got v=%b y=%b want 0 0", mem_req.valid, mem_req.yumi); end
        checks++; if (core_resp !== '0) begin errors++; $display("FAIL rnd_idle_resp: got %h want 0", core_resp); end
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && vld_now[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) begin
          busy = 1'b1; owner = w;
          checks++; if (c_starve[w] > N - 1)
            begin errors++; $display("FAIL rnd_fairness: core %0d waited %0d want <= %0d", w, c_starve[w], N - 1); end
          c_starve[w] = 0;
        end
      end else begin
        o = owner;
        exp_cy = (c_st[o] == 1) && m_yumi;
        exp_cv = (c_st[o] == 2) && m_vld;
        exp_mv = (c_st[o] == 1);
        exp_my = (c_st[o] == 2) && c_yumi[o];
        checks++; if (grant !== onehot(o)) begin errors++; $display("FAIL rnd_grant: got %b want %b", grant, onehot(o)); end
        checks++; if (mem_req.valid !== exp_mv || mem_req.yumi !== exp_my)
          begin errors++; $display("FAIL rnd_mem_hs: got v=%b y=%b want %b %b", mem_req.valid, mem_req.yumi, exp_mv, exp_my); end
        checks++; if (core_resp[o].yumi !== exp_cy || core_resp[o].valid !== exp_cv)
          begin errors++; $display("FAIL rnd_core_hs: core %0d got y=%b v=%b want %b %b", o, core_resp[o].yumi, core_resp[o].valid, exp_cy, exp_cv); end
        if (exp_cv) begin
          checks++; if (core_resp[o].read_data !== rd_of(m_adr))
            begin errors++; $display("FAIL rnd_rdata: got %h want %h", core_resp[o].read_data, rd_of(m_adr)); end
        end
        if (exp_mv) begin
          checks++; if (mem_addr !== c_adr[o] || mem_req.write_data !== c_wd[o] || mem_req.wen !== c_wen[o] || mem_req.byte_not_word !== c_bnw[o])
            begin errors++; $display("FAIL rnd_req_fields: got a=%h d=%h w=%b b=%b want %h %h %b %b", mem_addr, mem_req.write_data,
                                     mem_req.wen, mem_req.byte_not_word, c_adr[o], c_wd[o], c_wen[o], c_bnw[o]); end
        end
        for (int i = 0; i < N; i++) if (i != o) begin
          checks++; if (core_resp[i] !== '0) begin errors++; $display("FAIL rnd_non_owner: core %0d got %h want 0", i, core_resp[i]); end
        end
        if (exp_cy) begin
          c_st[o] = 2; c_wq[o] = 0;
        end else if (exp_cv && c_yumi[o]) begin
          mem_ack = 1'b1; c_st[o] = 0; c_left[o]--; total++; busy = 1'b0; ptr = (o + 1) % N;
          for (int i = 0; i < N; i++) if (c_st[i] == 1) c_starve[i]++;
        end
      end
      if (m_ph == 0 && !m_seen && mem_req.valid === 1'b1) begin
        m_seen = 1'b1; m_ydly = $urandom_range(1); m_last_addr = mem_addr;
      end
      if (m_yumi) m_seen = 1'b0;
      if (m_ph == 1 && m_vld && mem_ack) m_ph = 0;
    end
    checks++; if (total != N * TXN) begin errors++; $display("FAIL rnd_complete: got %0d transactions want %0d", total, N * TXN); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    core_req[1].valid = 1'b1; core_addr[1] = 32'h100;
    core_req[2].valid = 1'b1; core_addr[2] = 32'h200;
    for (int k = 0; k <= TMO; k++) begin
      @(negedge clk);
      checks++; if (err !== (k == TMO)) begin errors++; $display("FAIL tmo_err: cycle %0d got %b want %b", k, err, (k == TMO)); end
      checks++; if (grant !== ((k < TMO) ? 4'b0010 : 4'b0000))
        begin errors++; $display("FAIL tmo_grant: cycle %0d got %b", k, grant); end
      checks++; if (core_resp[1].yumi !== 1'b0) begin errors++; $display("FAIL tmo_yumi: got %b want 0", core_resp[1].yumi); end
    end
    checks++; if (mem_req.valid !== 1'b0) begin errors++; $display("FAIL tmo_idle_valid: got %b want 0", mem_req.valid); end
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL tmo_next_grant: got %b want 0100", grant); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", err); end
    clear_inputs();
  endtask

  task automatic test_abandon();
    do_reset();
    core_req[1].valid = 1'b1; core_addr[1] = 32'h44;
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || mem_req.valid !== 1'b1 || mem_addr !== 32'h44)
      begin errors++; $display("FAIL abn_req: got g=%b v=%b a=%h want 0010 1 44", grant, mem_req.valid, mem_addr); end
    core_req[1].valid = 1'b0;
    core_req[0].valid = 1'b1;
    core_req[2].valid = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0000 || err !== 1'b0)
      begin errors++; $display("FAIL abn_idle: got g=%b e=%b want 0000 0", grant, err); end
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL abn_ptr: got %b want 0100", grant); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_req[2].valid = 1'b1;
    @(negedge clk);
    core_req[2].valid = 1'b0;
    @(negedge clk);
    core_req[1].valid = 1'b1; core_addr[1] = 32'h40;
    @(negedge clk);
    mem_resp.yumi = 1'b1;
    @(negedge clk);
    mem_resp.yumi = 1'b0;
    core_req[1].valid = 1'b0; core_req[1].yumi = 1'b1;
    core_req[0].valid = 1'b1; core_req[2].valid = 1'b1; core_req[3].valid = 1'b1;
    #1;
    checks++; if (mem_req.yumi !== 1'b1 || grant !== 4'b0010)
      begin errors++; $display("FAIL rstm_pre: got y=%b g=%b want 1 0010", mem_req.yumi, grant); end
    #1 reset = 1'b0;
    #1;
    checks++; if (mem_req.valid !== 1'b0 || mem_req.yumi !== 1'b0)
      begin errors++; $display("FAIL rstm_mem: got v=%b y=%b want 0 0", mem_req.valid, mem_req.yumi); end
    checks++; if (grant !== '0 || core_resp !== '0)
      begin errors++; $display("FAIL rstm_grant: got g=%b r=%h want 0 0", grant, core_resp); end
    @(negedge clk);
    reset = 1'b1;
    core_req[1].yumi = 1'b0; core_req[1].valid = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rstm_first: got %b want 0001", grant); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_random();
    test_timeout();
    test_abandon();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
